// File: rtl/demux_b_pkg.sv
// Shared widths and types for the B-side 1-to-4 distributor.
// Statistics counters are enabled by defining DEMUX_B_STATS_EN.
package demux_b_pkg;

  localparam int DEMUX_B_WIDTH    = 32;
  localparam int DEMUX_B_NUM_DEST = 4;
  localparam int DEMUX_B_CNT_W    = 16;

  typedef logic [1:0]               demux_b_sel_t;
  typedef logic [DEMUX_B_WIDTH-1:0] demux_b_word_t;

endpackage

// File: rtl/demux_b_slot.sv
// One holding slot: a data register plus a valid flag.
// A load has priority over an ack, so a slot can stream one word per cycle.
module demux_b_slot
  import demux_b_pkg::*;
#(
  parameter int WIDTH = DEMUX_B_WIDTH
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             i_load,
  input  logic             i_ack,
  input  logic [WIDTH-1:0] i_load_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid
);

  logic [WIDTH-1:0] r_data;
  logic             r_valid;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its inputs, independent of block order.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_data  <= i_load_data;
      r_valid <= 1'b1;
    end else if (i_ack) begin
      // Ack on an empty slot leaves r_valid at 0; data is never cleared here.
      r_valid <= 1'b0;
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;

endmodule

// File: rtl/demux_b.sv
// Registered 1-to-4 distributor with per-slot valid/ack handshake.
// Optional Accept_Count/Stall_Count ports exist only with DEMUX_B_STATS_EN.
module demux_b
  import demux_b_pkg::*;
#(
  parameter int WIDTH = DEMUX_B_WIDTH
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             In_Valid,
  output logic             In_Ready,
  input  logic [WIDTH-1:0] In_Data,
  input  logic [1:0]       S_B,
  output logic [WIDTH-1:0] Out_D0,
  output logic [WIDTH-1:0] Out_D1,
  output logic [WIDTH-1:0] Out_D2,
  output logic [WIDTH-1:0] Out_D3,
  output logic [3:0]       Out_Valid,
  input  logic [3:0]       Out_Ack
`ifdef DEMUX_B_STATS_EN
  ,
  output logic [15:0]      Accept_Count,
  output logic [15:0]      Stall_Count
`endif
);

  demux_b_sel_t                       w_sel;
  logic                               w_accept;
  logic [DEMUX_B_NUM_DEST-1:0]        w_load;
  logic [DEMUX_B_NUM_DEST-1:0]        w_valid;
  logic [WIDTH-1:0]                   w_data [DEMUX_B_NUM_DEST];

  assign w_sel = S_B;

  // Ack-to-Ready is combinational on purpose: a full slot being drained this
  // cycle can take the next word on the same edge.
  assign In_Ready = !w_valid[w_sel] || Out_Ack[w_sel];
  assign w_accept = In_Valid && In_Ready;

  // NOTE: every signal written in always_comb gets a default first, so no
  // path through the block leaves it unassigned and infers a latch.
  always_comb begin
    w_load = '0;
    if (w_accept) w_load[w_sel] = 1'b1;
  end

  for (genvar g = 0; g < DEMUX_B_NUM_DEST; g++) begin : g_slot
    demux_b_slot #(.WIDTH(WIDTH)) u_slot (
      .Clk         (Clk),
      .Reset       (Reset),
      .i_load      (w_load[g]),
      .i_ack       (Out_Ack[g]),
      .i_load_data (In_Data),
      .o_data      (w_data[g]),
      .o_valid     (w_valid[g])
    );
  end

  assign Out_D0    = w_data[0];
  assign Out_D1    = w_data[1];
  assign Out_D2    = w_data[2];
  assign Out_D3    = w_data[3];
  assign Out_Valid = w_valid;

`ifdef DEMUX_B_STATS_EN
  logic [DEMUX_B_CNT_W-1:0] r_accept_count;
  logic [DEMUX_B_CNT_W-1:0] r_stall_count;

  // Both counters wrap naturally at their width.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_accept_count <= '0;
      r_stall_count  <= '0;
    end else begin
      if (w_accept)              r_accept_count <= r_accept_count + DEMUX_B_CNT_W'(1);
      if (In_Valid && !In_Ready) r_stall_count  <= r_stall_count + DEMUX_B_CNT_W'(1);
    end
  end

  assign Accept_Count = r_accept_count;
  assign Stall_Count  = r_stall_count;
`endif

endmodule

// File: tb/tb_demux_b.sv
// Self-checking bench for demux_b: directed scenarios plus a randomized run
// against a slot-array reference model. Counter checks need DEMUX_B_STATS_EN.
module tb_demux_b;

  logic        Clk;
  logic        Reset;
  logic        In_Valid;
  logic        In_Ready;
  logic [31:0] In_Data;
  logic [1:0]  S_B;
  logic [31:0] Out_D0, Out_D1, Out_D2, Out_D3;
  logic [3:0]  Out_Valid;
  logic [3:0]  Out_Ack;
`ifdef DEMUX_B_STATS_EN
  logic [15:0] Accept_Count;
  logic [15:0] Stall_Count;
`endif

  demux_b dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .In_Valid  (In_Valid),
    .In_Ready  (In_Ready),
    .In_Data   (In_Data),
    .S_B       (S_B),
    .Out_D0    (Out_D0),
    .Out_D1    (Out_D1),
    .Out_D2    (Out_D2),
    .Out_D3    (Out_D3),
    .Out_Valid (Out_Valid),
    .Out_Ack   (Out_Ack)
`ifdef DEMUX_B_STATS_EN
    ,
    .Accept_Count (Accept_Count),
    .Stall_Count  (Stall_Count)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: four slots, each a word plus an "occupied" flag.
  logic [31:0] m_data [4];
  logic [3:0]  m_valid;
  logic [15:0] m_acc;
  logic [15:0] m_stall;
  logic        obs_ready;
  logic        exp_ready;
  logic [31:0] obs_d [4];

  assign obs_d[0] = Out_D0;
  assign obs_d[1] = Out_D1;
  assign obs_d[2] = Out_D2;
  assign obs_d[3] = Out_D3;

  task automatic model_clear();
    for (int n = 0; n < 4; n++) m_data[n] = '0;
    m_valid = '0;
    m_acc   = '0;
    m_stall = '0;
  endtask

  // Drives one cycle, samples In_Ready before the edge, advances the model.
  task automatic drive_cycle(input logic v, input logic [1:0] s,
                             input logic [31:0] d, input logic [3:0] a);
    logic take;
    In_Valid = v;
    S_B      = s;
    In_Data  = d;
    Out_Ack  = a;
    #1;
    obs_ready = In_Ready;
    exp_ready = !(m_valid[s] && !a[s]);
    take      = v && exp_ready;
    @(posedge Clk);
    for (int n = 0; n < 4; n++) begin
      if (take && (s == n)) begin
        m_data[n]  = d;
        m_valid[n] = 1'b1;
      end else if (a[n]) begin
        m_valid[n] = 1'b0;
      end
    end
    if (take)            m_acc   = m_acc + 16'd1;
    if (v && !exp_ready) m_stall = m_stall + 16'd1;
    #1;
  endtask

  task automatic test_reset();
    n_checks++;
    if (Out_Valid !== 4'b0000) begin
      n_fail++; $display("FAIL reset_valid: got %b expected 0000", Out_Valid);
    end
    for (int n = 0; n < 4; n++) begin
      n_checks++;
      if (obs_d[n] !== 32'h0) begin
        n_fail++; $display("FAIL reset_data%0d: got %h expected 00000000", n, obs_d[n]);
      end
    end
    n_checks++;
    if (In_Ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready: got %b expected 1", In_Ready);
    end
`ifdef DEMUX_B_STATS_EN
    n_checks++;
    if (Accept_Count !== 16'd0 || Stall_Count !== 16'd0) begin
      n_fail++; $display("FAIL reset_counts: got %0d/%0d expected 0/0", Accept_Count, Stall_Count);
    end
`endif
  endtask

  task automatic test_single();
    drive_cycle(1'b1, 2'd2, 32'h0000_8000, 4'b0000);
    n_checks++;
    if (obs_ready !== 1'b1) begin
      n_fail++; $display("FAIL single_ready: got %b expected 1", obs_ready);
    end
    n_checks++;
    if (Out_Valid !== 4'b0100) begin
      n_fail++; $display("FAIL single_valid: got %b expected 0100", Out_Valid);
    end
    for (int n = 0; n < 4; n++) begin
      n_checks++;
      if (obs_d[n] !== ((n == 2) ? 32'h0000_8000 : 32'h0)) begin
        n_fail++; $display("FAIL single_data%0d: got %h expected %h", n, obs_d[n],
                           (n == 2) ? 32'h0000_8000 : 32'h0);
      end
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b1, 2'd2, 32'h1234_5678, 4'b0000);
      n_checks++;
      if (obs_ready !== 1'b0 || Out_D2 !== 32'h0000_8000) begin
        n_fail++; $display("FAIL stall_hold: got ready=%b d2=%h expected ready=0 d2=00008000",
                           obs_ready, Out_D2);
      end
    end
`ifdef DEMUX_B_STATS_EN
    n_checks++;
    if (Stall_Count !== 16'd3) begin
      n_fail++; $display("FAIL stall_count: got %0d expected 3", Stall_Count);
    end
`endif
    drive_cycle(1'b1, 2'd2, 32'h1234_5678, 4'b0100);
    n_checks++;
    if (obs_ready !== 1'b1 || Out_D2 !== 32'h1234_5678 || Out_Valid !== 4'b0100) begin
      n_fail++; $display("FAIL stall_release: got ready=%b d2=%h valid=%b expected 1/12345678/0100",
                         obs_ready, Out_D2, Out_Valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] words [4];
    words[0] = 32'd1; words[1] = 32'd128; words[2] = 32'd32768; words[3] = 32'd8388608;
    drive_cycle(1'b0, 2'd0, 32'h0, 4'b1111);
    for (int n = 0; n < 4; n++) begin
      drive_cycle(1'b1, 2'(n), words[n], 4'b0000);
      n_checks++;
      if (obs_ready !== 1'b1) begin
        n_fail++; $display("FAIL b2b_ready%0d: got %b expected 1", n, obs_ready);
      end
    end
    n_checks++;
    if (Out_Valid !== 4'b1111) begin
      n_fail++; $display("FAIL b2b_valid: got %b expected 1111", Out_Valid);
    end
    for (int n = 0; n < 4; n++) begin
      n_checks++;
      if (obs_d[n] !== words[n]) begin
        n_fail++; $display("FAIL b2b_data%0d: got %h expected %h", n, obs_d[n], words[n]);
      end
    end
    drive_cycle(1'b1, 2'd1, 32'hDEAD_BEEF, 4'b0000);
    n_checks++;
    if (obs_ready !== 1'b0 || Out_D1 !== 32'd128) begin
      n_fail++; $display("FAIL b2b_stall: got ready=%b d1=%h expected 0/00000080", obs_ready, Out_D1);
    end
  endtask

  task automatic test_drain();
    for (int pass = 0; pass < 2; pass++) begin
      drive_cycle(1'b0, 2'(pass), 32'hFFFF_FFFF, 4'b1111);
      n_checks++;
      if (Out_Valid !== 4'b0000) begin
        n_fail++; $display("FAIL drain_valid%0d: got %b expected 0000", pass, Out_Valid);
      end
      for (int n = 0; n < 4; n++) begin
        n_checks++;
        if (obs_d[n] !== m_data[n]) begin
          n_fail++; $display("FAIL drain_data%0d: got %h expected %h", n, obs_d[n], m_data[n]);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    drive_cycle(1'b1, 2'd1, 32'hA5A5_0001, 4'b0000);
    drive_cycle(1'b1, 2'd3, 32'hA5A5_0003, 4'b0000);
    n_checks++;
    if (Out_Valid !== 4'b1010) begin
      n_fail++; $display("FAIL areset_setup: got %b expected 1010", Out_Valid);
    end
    In_Valid = 1'b0;
    #3;
    Reset = 1'b1;
    #1;
    model_clear();
    n_checks++;
    if (Out_Valid !== 4'b0000 || Out_D1 !== 32'h0 || Out_D3 !== 32'h0) begin
      n_fail++; $display("FAIL areset_clear: got valid=%b d1=%h d3=%h expected all zero",
                         Out_Valid, Out_D1, Out_D3);
    end
    n_checks++;
    if (In_Ready !== 1'b1) begin
      n_fail++; $display("FAIL areset_ready: got %b expected 1", In_Ready);
    end
    #2;
    Reset = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      drive_cycle(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), $urandom,
                  4'($urandom_range(0, 15) & $urandom_range(0, 15)));
      n_checks++;
      if (obs_ready !== exp_ready || Out_Valid !== m_valid) begin
        n_fail++; $display("FAIL rand_ctrl[%0d]: got ready=%b valid=%b expected %b/%b",
                           i, obs_ready, Out_Valid, exp_ready, m_valid);
      end
      for (int n = 0; n < 4; n++) begin
        n_checks++;
        if (obs_d[n] !== m_data[n]) begin
          n_fail++; $display("FAIL rand_data%0d[%0d]: got %h expected %h", n, i, obs_d[n], m_data[n]);
        end
      end
    end
`ifdef DEMUX_B_STATS_EN
    n_checks++;
    if (Accept_Count !== m_acc || Stall_Count !== m_stall) begin
      n_fail++; $display("FAIL rand_counts: got %0d/%0d expected %0d/%0d",
                         Accept_Count, Stall_Count, m_acc, m_stall);
    end
`endif
  endtask

`ifdef DEMUX_B_STATS_EN
  task automatic test_wrap();
    Reset = 1'b1;
    #2;
    Reset = 1'b0;
    model_clear();
    for (int i = 0; i < 65537; i++) drive_cycle(1'b1, 2'd0, 32'(i), 4'b0001);
    n_checks++;
    if (Accept_Count !== 16'd1) begin
      n_fail++; $display("FAIL wrap_accept: got %0d expected 1", Accept_Count);
    end
  endtask
`endif

  initial begin
    Reset    = 1'b1;
    In_Valid = 1'b0;
    In_Data  = '0;
    S_B      = '0;
    Out_Ack  = '0;
    model_clear();
    #12;
    Reset = 1'b0;
    #1;
    test_reset();
    test_single();
    test_stall();
    test_back_to_back();
    test_drain();
    test_async_reset();
    test_random();
`ifdef DEMUX_B_STATS_EN
    test_wrap();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
